an_rx_sqrt_arb: RTL and testbench



---
 rtl/an_rx_sqrt_arb_pkg.sv | 24 ++
 rtl/an_rx_sqrt_arb_rr_pick.sv | 30 +++
 rtl/an_rx_sqrt_arb.sv | 167 ++++++++++++++++
 tb/tb_an_rx_sqrt_arb.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/an_rx_sqrt_arb_pkg.sv
// an_rx_sqrt_arb_pkg: shared types and constants for the AN receive SQRT arbiter.
// Holds the arbiter state encoding, the channel-index width helper and the
// default root width / watchdog limit.
package an_rx_sqrt_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_PUB   = 2'd3
  } arb_st_e;

  localparam int AN_SQ_W_DEF   = 12;
  localparam int AN_SQ_TMO_DEF = 64;

  // ceil(log2(n)), never below 1 so a channel index always has a bit
  function automatic int ch_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/an_rx_sqrt_arb_rr_pick.sv
// an_rx_rr_pick: combinational rotate-priority encoder. Searches the pending
// mask starting one past the last granted channel, wrapping modulo C_CH, and
// returns whether anything is pending plus the first hit.
module an_rx_rr_pick #(
  parameter int C_CH = 4,
  parameter int CW   = 2
) (
  input  logic [C_CH-1:0] pend,
  input  logic [CW-1:0]   last,
  output logic            any,
  output logic [CW-1:0]   sel
);

  logic [CW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest pending channel wins
  always_comb begin
    any = 1'b0;
    sel = '0;
    idx = '0;
    for (int i = C_CH; i >= 1; i--) begin
      idx = CW'((int'(last) + i) % C_CH);
      if (pend[idx]) begin
        any = 1'b1;
        sel = idx;
      end
    end
  end

endmodule

// File: rtl/an_rx_sqrt_arb.sv
// an_rx_sqrt_arb: round-robin share of one SQRT engine among C_CH level
// detectors. One pending word per channel, one engine transaction at a time,
// results published with their channel and kept per channel in LVs_o.
// Optional watchdog: define AN_RX_SQRT_ARB_WDOG_EN to abort a WAIT that lasts
// C_TMO cycles, publishing an all-ones root and setting sticky TMO_o.
module an_rx_sqrt_arb
  import an_rx_sqrt_arb_pkg::*;
#(
  parameter int C_CH  = 4,
  parameter int C_W   = AN_SQ_W_DEF,
  parameter int C_TMO = AN_SQ_TMO_DEF
) (
  input  logic                    CK_i,
  input  logic                    RST_i,
  input  logic [C_CH-1:0]         REQs_i,
  input  logic [C_CH*2*C_W-1:0]   DATs_i,
  output logic                    SQ_REQ_o,
  output logic [2*C_W-1:0]        SQ_DATs_o,
  input  logic [C_W-1:0]          SQ_QQs_i,
  input  logic                    SQ_DONE_i,
  output logic [C_W-1:0]          QQs_o,
  output logic [ch_w(C_CH)-1:0]   CH_o,
  output logic                    VLD_o,
  output logic [C_CH*C_W-1:0]     LVs_o,
  output logic [C_CH-1:0]         OVRs_o,
  input  logic                    OVR_CLR_i,
  output logic                    BUSY_o,
  output logic                    TMO_o
);

  localparam int CW = ch_w(C_CH);

  arb_st_e                       st_q, st_d;
  logic [C_CH-1:0]               pend_q;
  logic [C_CH-1:0][2*C_W-1:0]    dat_q;
  logic [C_CH-1:0][2*C_W-1:0]    dat_in;
  logic [C_CH-1:0][C_W-1:0]      lv_q;
  logic [C_CH-1:0]               ovr_q;
  logic [C_CH-1:0]               gnt_hit;
  logic [CW-1:0]                 last_q, gnt_q, ch_q, sel;
  logic [2*C_W-1:0]              sq_dat_q;
  logic [C_W-1:0]                qq_q;
  logic                          any, gnt_fire, done_fire, tmo_hit;

  assign dat_in = DATs_i;

  an_rx_rr_pick #(.C_CH(C_CH), .CW(CW)) u_pick (
    .pend (pend_q),
    .last (last_q),
    .any  (any),
    .sel  (sel)
  );

  assign gnt_fire  = (st_q == ST_IDLE) && any;
  // DONE only counts in WAIT; an early pulse during ISSUE is dropped
  assign done_fire = (st_q == ST_WAIT) && SQ_DONE_i;

  // One-hot of the channel granted this cycle (zero when no grant)
  always_comb begin
    gnt_hit = '0;
    for (int k = 0; k < C_CH; k++)
      gnt_hit[k] = gnt_fire && (sel == CW'(k));
  end

  // State register
  always_ff @(posedge CK_i) begin
    if (RST_i) st_q <= ST_IDLE;
    else       st_q <= st_d;
  end

  // Next-state: grant -> one-cycle issue -> wait for root -> one-cycle publish
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE:  if (any) st_d = ST_ISSUE;
      ST_ISSUE: st_d = ST_WAIT;
      ST_WAIT:  if (SQ_DONE_i || tmo_hit) st_d = ST_PUB;
      ST_PUB:   st_d = ST_IDLE;
      default:  st_d = ST_IDLE;
    endcase
  end

  // Per-channel pending slot and sticky overrun; a request in the grant cycle
  // simply re-arms the slot since the old word has already been taken
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      pend_q <= '0;
      dat_q  <= '0;
      ovr_q  <= '0;
    end else begin
      for (int k = 0; k < C_CH; k++) begin
        if (REQs_i[k]) begin
          pend_q[k] <= 1'b1;
          dat_q[k]  <= dat_in[k];
        end else if (gnt_hit[k]) begin
          pend_q[k] <= 1'b0;
        end
        if (REQs_i[k] && pend_q[k] && !gnt_hit[k]) ovr_q[k] <= 1'b1;
        else if (OVR_CLR_i)                         ovr_q[k] <= 1'b0;
      end
    end
  end

  // Grant bookkeeping, engine operand and result capture
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      last_q   <= CW'(C_CH - 1);
      gnt_q    <= '0;
      sq_dat_q <= '0;
      qq_q     <= '0;
      ch_q     <= '0;
      lv_q     <= '0;
    end else begin
      if (gnt_fire) begin
        last_q   <= sel;
        gnt_q    <= sel;
        sq_dat_q <= dat_q[sel];
      end
      if (done_fire) begin
        qq_q        <= SQ_QQs_i;
        ch_q        <= gnt_q;
        lv_q[gnt_q] <= SQ_QQs_i;
      end else if (tmo_hit) begin
        qq_q        <= '1;
        ch_q        <= gnt_q;
        lv_q[gnt_q] <= '1;
      end
    end
  end

`ifdef AN_RX_SQRT_ARB_WDOG_EN
  localparam int TW = $clog2(C_TMO + 1);

  logic [TW-1:0] wd_q;
  logic          tmo_q;

  // Fires on the C_TMO-th WAIT cycle if the engine still has not answered
  assign tmo_hit = (st_q == ST_WAIT) && !SQ_DONE_i && (wd_q == TW'(C_TMO - 1));

  // WAIT-cycle counter and sticky timeout flag
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else begin
      if (st_q == ST_WAIT) wd_q <= wd_q + 1'b1;
      else                 wd_q <= '0;
      if (tmo_hit) tmo_q <= 1'b1;
    end
  end

  assign TMO_o = tmo_q;
`else
  assign tmo_hit = 1'b0;
  assign TMO_o   = 1'b0;
`endif

  assign SQ_REQ_o  = (st_q == ST_ISSUE);
  assign SQ_DATs_o = sq_dat_q;
  assign QQs_o     = qq_q;
  assign CH_o      = ch_q;
  assign VLD_o     = (st_q == ST_PUB);
  assign LVs_o     = lv_q;
  assign OVRs_o    = ovr_q;
  assign BUSY_o    = (st_q != ST_IDLE);

endmodule

// File: tb/tb_an_rx_sqrt_arb.sv
// tb_an_rx_sqrt_arb: directed bench for an_rx_sqrt_arb with a behavioural
// SQRT engine (fixed latency, integer root) and hand-computed expectations.
module tb_an_rx_sqrt_arb;
  localparam int C_CH = 4, C_W = 12, C_TMO = 64;

  logic               CK = 1'b0;
  logic               RST;
  logic [C_CH-1:0]    REQs;
  logic [C_CH*24-1:0] dats;
  logic               SQ_REQ;
  logic [23:0]        SQ_DATs;
  logic [C_W-1:0]     sq_qq;
  logic               sq_done;
  logic [C_W-1:0]     QQs;
  logic [1:0]         CH;
  logic               VLD;
  logic [C_CH*C_W-1:0] LVs;
  logic [C_CH-1:0]    OVRs;
  logic               OVR_CLR;
  logic               BUSY;
  logic               TMO;

  int n_cmp = 0, n_err = 0;
  int mdl_en = 1, mdl_lat = 2;
  logic [23:0] issues[$];
  bit   m_busy = 1'b0;
  int   m_cnt  = 0;
  logic [23:0] m_op = '0;

  always #5 CK = ~CK;

  an_rx_sqrt_arb #(.C_CH(C_CH), .C_W(C_W), .C_TMO(C_TMO)) dut (
    .CK_i      (CK),
    .RST_i     (RST),
    .REQs_i    (REQs),
    .DATs_i    (dats),
    .SQ_REQ_o  (SQ_REQ),
    .SQ_DATs_o (SQ_DATs),
    .SQ_QQs_i  (sq_qq),
    .SQ_DONE_i (sq_done),
    .QQs_o     (QQs),
    .CH_o      (CH),
    .VLD_o     (VLD),
    .LVs_o     (LVs),
    .OVRs_o    (OVRs),
    .OVR_CLR_i (OVR_CLR),
    .BUSY_o    (BUSY),
    .TMO_o     (TMO)
  );

  function automatic int unsigned isqrt(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // SQRT engine model: ignores reset on purpose so a late DONE can follow it
  always begin
    @(posedge CK);
    #1;
    sq_done = 1'b0;
    if (m_busy) begin
      if (m_cnt == 0) begin
        sq_done = 1'b1;
        sq_qq   = C_W'(isqrt(32'(m_op)));
        m_busy  = 1'b0;
      end else m_cnt--;
    end
    if (SQ_REQ) begin
      issues.push_back(SQ_DATs);
      if (mdl_en != 0) begin
        m_busy = 1'b1;
        m_cnt  = mdl_lat - 1;
        m_op   = SQ_DATs;
      end
    end
  end

  task automatic post(input int ch, input logic [23:0] val);
    REQs[ch] = 1'b1;
    dats[ch*24 +: 24] = val;
    tick();
    REQs = '0;
  endtask

  task automatic wait_vld(input string tag, input int exp_ch, input int exp_qq);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (VLD === 1'b1) ok = 1'b1;
    end
    chk({tag, "_vld"}, 64'(ok), 1);
    if (ok) begin
      chk({tag, "_ch"}, 64'(CH), 64'(exp_ch));
      chk({tag, "_qq"}, 64'(QQs), 64'(exp_qq));
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 64'(BUSY), 0);
    chk({tag, "_sqreq"}, 64'(SQ_REQ), 0);
    chk({tag, "_sqdat"}, 64'(SQ_DATs), 0);
    chk({tag, "_qq"}, 64'(QQs), 0);
    chk({tag, "_ch"}, 64'(CH), 0);
    chk({tag, "_vld"}, 64'(VLD), 0);
    chk({tag, "_lv"}, 64'(LVs), 0);
    chk({tag, "_ovr"}, 64'(OVRs), 0);
    chk({tag, "_tmo"}, 64'(TMO), 0);
  endtask

  initial begin
    int nv, nb;
    RST = 1'b1; REQs = '0; dats = '0; OVR_CLR = 1'b0;
    sq_done = 1'b0; sq_qq = '0;
    tick(); tick();
    chk_reset("rst");
    RST = 1'b0;

    // single request on ch2
    post(2, 24'h000900);
    chk("t1_sqreq_c1", 64'(SQ_REQ), 0);
    tick();
    chk("t1_sqreq_c2", 64'(SQ_REQ), 1);
    chk("t1_sqdat", 64'(SQ_DATs), 64'h900);
    tick();
    chk("t1_sqreq_once", 64'(SQ_REQ), 0);
    chk("t1_sqdat_hold", 64'(SQ_DATs), 64'h900);
    wait_vld("t1", 2, 'h30);
    chk("t1_lv2", 64'(LVs[2*C_W +: C_W]), 'h30);
    tick();
    chk("t1_vld_once", 64'(VLD), 0);

    // burst from reset: 0,1,2,3 ; after a ch1 grant: 2,3,0,1
    RST = 1'b1; tick(); RST = 1'b0;
    REQs = '1; dats = {24'd25, 24'd16, 24'd9, 24'd4}; tick(); REQs = '0;
    wait_vld("t2a0", 0, 2);
    wait_vld("t2a1", 1, 3);
    wait_vld("t2a2", 2, 4);
    wait_vld("t2a3", 3, 5);
    post(1, 24'd1);
    wait_vld("t2b", 1, 1);
    tick();
    REQs = '1; dats = {24'd144, 24'd121, 24'd100, 24'd81}; tick(); REQs = '0;
    wait_vld("t2c2", 2, 11);
    wait_vld("t2c3", 3, 12);
    wait_vld("t2c0", 0, 9);
    wait_vld("t2c1", 1, 10);

    // overrun on ch0 while ch3 holds the engine
    issues.delete();
    post(3, 24'd49);
    post(0, 24'd100);
    post(0, 24'd400);
    chk("t3_ovr0_set", 64'(OVRs[0]), 1);
    wait_vld("t3a", 3, 7);
    wait_vld("t3b", 0, 20);
    chk("t3_nissue", 64'(issues.size()), 2);
    chk("t3_iss_dat", 64'(issues[1]), 400);
    chk("t3_ovr_sticky", 64'(OVRs), 64'h1);
    OVR_CLR = 1'b1; tick(); OVR_CLR = 1'b0;
    chk("t3_ovr_clr", 64'(OVRs), 0);
    // set beats clear in the same cycle
    post(3, 24'd4);
    post(2, 24'd9);
    OVR_CLR = 1'b1;
    post(2, 24'd16);
    OVR_CLR = 1'b0;
    chk("t3_set_wins", 64'(OVRs), 64'h4);
    wait_vld("t3c", 3, 2);
    wait_vld("t3d", 2, 4);
    OVR_CLR = 1'b1; tick(); OVR_CLR = 1'b0;

    // ch1 re-request in its own grant cycle
    issues.delete();
    post(1, 24'd36);
    post(1, 24'd64);
    wait_vld("t4a", 1, 6);
    wait_vld("t4b", 1, 8);
    chk("t4_nissue", 64'(issues.size()), 2);
    chk("t4_iss0", 64'(issues[0]), 36);
    chk("t4_iss1", 64'(issues[1]), 64);
    chk("t4_ovr1", 64'(OVRs[1]), 0);

`ifdef AN_RX_SQRT_ARB_WDOG_EN
    // engine never answers ch1; ch2 is served after the timeout
    mdl_en = 0;
    post(1, 24'd4);
    post(2, 24'd9);
    wait_vld("t5a", 1, 'hFFF);
    chk("t5_tmo", 64'(TMO), 1);
    chk("t5_lv1", 64'(LVs[1*C_W +: C_W]), 'hFFF);
    mdl_en = 1;
    wait_vld("t5b", 2, 3);
    chk("t5_tmo_sticky", 64'(TMO), 1);
`else
    chk("t5_tmo_off", 64'(TMO), 0);
`endif

    // reset during WAIT, with ch1 pending and a late DONE from the engine
    mdl_lat = 8;
    issues.delete();
    post(0, 24'd81);
    tick(); tick();
    chk("t6_busy_wait", 64'(BUSY), 1);
    post(1, 24'd16);
    RST = 1'b1; tick(); RST = 1'b0;
    chk_reset("t6");
    nv = 0; nb = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (VLD === 1'b1) nv++;
      if (BUSY === 1'b1) nb++;
    end
    chk("t6_no_vld", 64'(nv), 0);
    chk("t6_no_grant", 64'(nb), 0);
    chk("t6_nissue", 64'(issues.size()), 1);
    mdl_lat = 2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
